// File: rtl/counter_pkg.sv
// Shared definitions for the cascaded modulo counters.
// Provides clog2, direction encodings and a parameter legality check.
`ifndef COUNTER_PKG_DEFS
`define COUNTER_PKG_DEFS
`define COUNTER_PARAM_CHECK(m, n) \
  if ((m) < 2 || (m) > 256 || (n) < 1 || (n) > 8) begin : g_bad_params \
    $error("mod_cascade_counter: illegal MOD/NUM_STAGES"); \
  end
`endif

package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_cnt_stage.sv
// One modulo-MOD digit of the cascade counter.
// Steps by +/-1 when cin is set; tc flags the terminal value.
module mod_cnt_stage
  import counter_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         cin,
  input  logic         up_dn,
  output logic [W-1:0] q,
  output logic         tc
);

  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] term;

  assign term = (up_dn == DIR_DN) ? '0 : MAXV;
  assign tc   = (q_q == term);
  assign q    = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = (32'(ld_val) >= MOD) ? MAXV : ld_val;
    end else if (cin) begin
      if (up_dn == DIR_UP) q_d = tc ? '0 : q_q + 1'b1;
      else                 q_d = tc ? MAXV : q_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q_q <= '0;
    else       q_q <= q_d;
  end

endmodule

// File: rtl/mod_cascade_counter.sv
// NUM_STAGES chained modulo-MOD digits with registered chain carry.
// Define COUNTER_SAT_EN to saturate at the terminal value instead of wrapping.
module mod_cascade_counter
  import counter_pkg::*;
#(
  parameter  int MOD        = 10,
  parameter  int NUM_STAGES = 2,
  localparam int W          = clog2(MOD)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clr,
  input  logic                    load,
  input  logic [NUM_STAGES*W-1:0] load_val,
  output logic [NUM_STAGES*W-1:0] cnt,
  output logic                    cout,
  output logic                    sat
);

  `COUNTER_PARAM_CHECK(MOD, NUM_STAGES)

  logic [NUM_STAGES-1:0] c;
  logic [NUM_STAGES-1:0] tc;
  logic [W-1:0]          q [NUM_STAGES];
  logic                  c0;
  logic                  ev;
  logic                  cout_q;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    mod_cnt_stage #(
      .W   (W),
      .MOD (MOD)
    ) u_stage (
      .clk    (clk),
      .rstn   (rstn),
      .clr    (clr),
      .load   (load),
      .ld_val (load_val[i*W +: W]),
      .cin    (c[i]),
      .up_dn  (up_dn),
      .q      (q[i]),
      .tc     (tc[i])
    );
    assign cnt[i*W +: W] = q[i];
    if (i == 0) begin : g_c0
      assign c[i] = c0;
    end else begin : g_ci
      assign c[i] = c[i-1] & tc[i-1];
    end
  end

`ifdef COUNTER_SAT_EN
  logic                  all_tc;
  logic [W-1:0]          pre;
  logic [NUM_STAGES-1:0] nt;
  logic                  sat_q;

  // Hold the whole chain instead of letting it wrap.
  assign all_tc = &tc;
  assign c0     = en & ~all_tc;
  assign pre    = (up_dn == DIR_UP) ? W'(MOD - 2) : W'(1);

  for (genvar j = 0; j < NUM_STAGES; j++) begin : g_nt
    assign nt[j] = c[j] ? (q[j] == pre) : tc[j];
  end

  assign ev  = c0 & (&nt);
  assign sat = sat_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sat_q <= 1'b0;
    else       sat_q <= ~clr & ~load & (ev | (sat_q & all_tc));
  end
`else
  assign c0  = en;
  assign ev  = c[NUM_STAGES-1] & tc[NUM_STAGES-1];
  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cout_q <= 1'b0;
    else       cout_q <= ~clr & ~load & ev;
  end

  assign cout = cout_q;

endmodule
